bv4_div_iter: RTL

BV4_DIV_ITER -- requirements
Module: bv4_div_iter

---
 rtl/aes128_package.sv | 22 ++
 rtl/bv4_mul.sv | 33 +++
 rtl/bv4_div_iter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aes128_package.sv
// Shared types for the GF(2^4) arithmetic blocks.
// bv4_t elements use Canright's tower representation: GF(2^4) over GF(2^2),
// both levels in a normal basis, so the field unity is all ones.
package aes128_package;

  typedef logic [3:0] bv4_t;

  localparam bv4_t BV4_ONE  = 4'hF;
  localparam bv4_t BV4_ZERO = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL1 = 3'd1,
    ST_MUL2 = 3'd2,
    ST_MUL3 = 3'd3,
    ST_MUL4 = 3'd4,
    ST_MUL5 = 3'd5,
    ST_MUL6 = 3'd6,
    ST_DONE = 3'd7
  } div_state_t;

endpackage

// File: rtl/bv4_mul.sv
// Combinational GF(2^4) multiplier in the tower/normal basis.
// Bits [3:2] are the GF(4) coefficient of Y^4, bits [1:0] that of Y,
// with Y^2 + Y + N = 0 and N = W^2. Inside GF(4), bit 1 is the W
// coefficient and bit 0 the W^2 coefficient.
module bv4_mul
  import aes128_package::*;
(
  input  bv4_t i_a,
  input  bv4_t i_b,
  output bv4_t o_p
);

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  // Multiply a GF(4) element by N = W^2.
  function automatic logic [1:0] gf4_scl_n(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  logic [1:0] w_hi;
  logic [1:0] w_lo;
  logic [1:0] w_e;

  assign w_hi = gf4_mul(i_a[3:2], i_b[3:2]);
  assign w_lo = gf4_mul(i_a[1:0], i_b[1:0]);
  assign w_e  = gf4_scl_n(gf4_mul(i_a[3:2] ^ i_a[1:0], i_b[3:2] ^ i_b[1:0]));
  assign o_p  = {w_hi ^ w_e, w_lo ^ w_e};

endmodule

// File: rtl/bv4_div_iter.sv
// Iterative GF(2^4) divider: q = num * den^14, den^14 being den^-1.
// One shared multiplier, one product per state, fixed schedule.
//
// state | meaning
// IDLE  | ready for operands
// MUL1  | t2 = a*a
// MUL2  | x  = t2*a      (a^3)
// MUL3  | x  = x*x       (a^6)
// MUL4  | x  = x*x       (a^12)
// MUL5  | x  = x*t2      (a^14 = a^-1)
// MUL6  | q  = x*b
// DONE  | result held until consumer takes it
//
// A zero divisor flows through the same datapath: 0^14 = 0, so q = 0.
module bv4_div_iter
  import aes128_package::*;
(
  input  logic in_clock,
  input  logic in_reset_n,
  input  bv4_t in_num,
  input  bv4_t in_den,
  input  logic in_valid,
  output logic out_ready,
  output bv4_t out_quot,
  output logic out_valid,
  input  logic in_ready,
  output logic out_div_zero
);

  div_state_t r_state;
  bv4_t       r_a;
  bv4_t       r_b;
  bv4_t       r_t2;
  bv4_t       r_x;
  bv4_t       r_q;
  logic       r_zero;
  logic       r_ready;
  logic       r_valid;
  logic       r_div_zero;

  bv4_t       w_mul_a;
  bv4_t       w_mul_b;
  bv4_t       w_prod;

  // Select the multiplier operands for the current schedule step.
  always_comb begin
    w_mul_a = r_x;
    w_mul_b = r_x;
    case (r_state)
      ST_MUL1: begin
        w_mul_a = r_a;
        w_mul_b = r_a;
      end
      ST_MUL2: begin
        w_mul_a = r_t2;
        w_mul_b = r_a;
      end
      ST_MUL5: begin
        w_mul_a = r_x;
        w_mul_b = r_t2;
      end
      ST_MUL6: begin
        w_mul_a = r_x;
        w_mul_b = r_b;
      end
      default: begin
        w_mul_a = r_x;
        w_mul_b = r_x;
      end
    endcase
  end

  bv4_mul u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // Sequencer: operand capture, product registration and output handshake.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state    <= ST_IDLE;
      r_a        <= BV4_ZERO;
      r_b        <= BV4_ZERO;
      r_t2       <= BV4_ZERO;
      r_x        <= BV4_ZERO;
      r_q        <= BV4_ZERO;
      r_zero     <= 1'b0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_ready) begin
            r_a     <= in_den;
            r_b     <= in_num;
            r_zero  <= (in_den == BV4_ZERO);
            r_ready <= 1'b0;
            r_state <= ST_MUL1;
          end
        end
        ST_MUL1: begin
          r_t2    <= w_prod;
          r_state <= ST_MUL2;
        end
        ST_MUL2: begin
          r_x     <= w_prod;
          r_state <= ST_MUL3;
        end
        ST_MUL3: begin
          r_x     <= w_prod;
          r_state <= ST_MUL4;
        end
        ST_MUL4: begin
          r_x     <= w_prod;
          r_state <= ST_MUL5;
        end
        ST_MUL5: begin
          r_x     <= w_prod;
          r_state <= ST_MUL6;
        end
        ST_MUL6: begin
          r_q        <= w_prod;
          r_valid    <= 1'b1;
          r_div_zero <= r_zero;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (in_ready) begin
            r_q        <= BV4_ZERO;
            r_valid    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_q        <= BV4_ZERO;
          r_valid    <= 1'b0;
          r_div_zero <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // r_q is only non-zero while DONE, so the quotient reads zero otherwise.
  assign out_ready    = r_ready;
  assign out_valid    = r_valid;
  assign out_quot     = r_q;
  assign out_div_zero = r_div_zero;

endmodule
